dl_timer_arbiter: RTL and testbench

DL_TIMER_ARBITER -- requirements
Module: dl_timer_arbiter

---
 rtl/dl_timer_arbiter.sv | 103 ++++++++++
 tb/tb_dl_timer_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dl_timer_arbiter.sv
// Round-robin arbiter lending one shared interval counter to NUM_REQ requesters.
// Latency: grant one edge after req; RUN lasts len+1 cycles, then a one-cycle done pulse.
// No backpressure: req is dropped by the end of DONE. Optional abort under DL_TIMER_ARB_ABORT_EN.
module dl_timer_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int NUM_BITS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*NUM_BITS-1:0] req_len,
`ifdef DL_TIMER_ARB_ABORT_EN
   input  logic                        abort,
`endif
   output logic [NUM_REQ-1:0]          grant,
   output logic                        busy,
   output logic [NUM_BITS-1:0]         q,
   output logic [NUM_REQ-1:0]          done
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [NUM_BITS-1:0] len_r;
   logic [IW-1:0]       last_winner;
   logic                win_found;
   logic [IW-1:0]       win_idx;
   logic [IW-1:0]       cand;
   int                  scan;

   // Search starts just past the previous owner so every requester gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      scan      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan = (int'(last_winner) + k) % NUM_REQ;
         cand = IW'(scan);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         busy        <= 1'b0;
         q           <= '0;
         done        <= '0;
         len_r       <= '0;
         last_winner <= IW'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               done <= '0;
               if (win_found) begin
                  state       <= RUN;
                  grant       <= NUM_REQ'(1) << win_idx;
                  busy        <= 1'b1;
                  q           <= '0;
                  len_r       <= req_len[win_idx*NUM_BITS +: NUM_BITS];
                  last_winner <= win_idx;
               end
            end
            RUN: begin
`ifdef DL_TIMER_ARB_ABORT_EN
               if (abort) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
                  q     <= '0;
               end else
`endif
               if (q == len_r) begin
                  state <= DONE;
                  done  <= grant;
                  grant <= '0;
                  busy  <= 1'b0;
                  q     <= '0;
               end else begin
                  q <= q + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= '0;
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
               q     <= '0;
               done  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dl_timer_arbiter.sv
// Bench for dl_timer_arbiter: interval-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dl_timer_arbiter;
   localparam int NR = 4;
   localparam int NB = 8;

   logic                 clk;
   logic                 rst;
   logic [NR-1:0]        req;
   logic [NR*NB-1:0]     req_len;
`ifdef DL_TIMER_ARB_ABORT_EN
   logic                 abort;
`endif
   logic [NR-1:0]        grant;
   logic                 busy;
   logic [NB-1:0]        q;
   logic [NR-1:0]        done;

   int total = 0;
   int bad   = 0;

   dl_timer_arbiter #(.NUM_REQ(NR), .NUM_BITS(NB)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .req_len (req_len),
`ifdef DL_TIMER_ARB_ABORT_EN
      .abort   (abort),
`endif
      .grant   (grant),
      .busy    (busy),
      .q       (q),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an interval is an owner plus a countdown of RUN cycles left.
   int m_owner  = 0;
   int m_len    = 0;
   int m_left   = 0;
   int m_done   = 0;
   int m_last   = NR - 1;
   int model_ok = 0;

   always @(posedge clk) begin
      int found;
      int idx;
      if (rst) begin
         m_left = 0; m_done = 0; m_last = NR - 1; m_owner = 0; m_len = 0;
         model_ok = 1;
      end else if (m_done != 0) begin
         m_done = 0;
      end else if (m_left > 0) begin
`ifdef DL_TIMER_ARB_ABORT_EN
         if (abort) m_left = 0;
         else begin
`endif
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1;
`ifdef DL_TIMER_ARB_ABORT_EN
         end
`endif
      end else begin
         found = 0;
         for (int k = 1; k <= NR; k++) begin
            idx = (m_last + k) % NR;
            if (found == 0 && req[idx]) begin
               found   = 1;
               m_owner = idx;
               m_last  = idx;
               m_len   = int'((req_len >> (idx * NB)) & {{(NR*NB-NB){1'b0}}, {NB{1'b1}}});
               m_left  = m_len + 1;
            end
         end
      end
   end

   function automatic logic [31:0] exp_grant();
      return (m_left > 0) ? (32'd1 << m_owner) : 32'd0;
   endfunction
   function automatic logic [31:0] exp_busy();
      return (m_left > 0) ? 32'd1 : 32'd0;
   endfunction
   function automatic logic [31:0] exp_q();
      return (m_left > 0) ? 32'(m_len + 1 - m_left) : 32'd0;
   endfunction
   function automatic logic [31:0] exp_done();
      return (m_done != 0) ? (32'd1 << m_owner) : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_ok != 0) begin
         chk("model grant", 32'(grant), exp_grant());
         chk("model busy",  32'(busy),  exp_busy());
         chk("model q",     32'(q),     exp_q());
         chk("model done",  32'(done),  exp_done());
      end
   end

   task automatic expect_cyc(input string name, input int g, input int b, input int qq, input int d);
      @(negedge clk);
      chk({name, " grant"}, 32'(grant), 32'(g));
      chk({name, " busy"},  32'(busy),  32'(b));
      chk({name, " q"},     32'(q),     32'(qq));
      chk({name, " done"},  32'(done),  32'(d));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; req_len = '0;
`ifdef DL_TIMER_ARB_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_len(input int i, input int v);
      req_len[i*NB +: NB] = NB'(v);
   endtask

   initial begin
      rst = 1'b1; req = '0; req_len = '0;
`ifdef DL_TIMER_ARB_ABORT_EN
      abort = 1'b0;
`endif
      do_reset();
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset busy",  32'(busy),  32'd0);
      chk("reset q",     32'(q),     32'd0);
      chk("reset done",  32'(done),  32'd0);

      // Single requester, len 3: four RUN cycles, done, idle.
      req = 4'b0001; set_len(0, 3);
      for (int i = 0; i < 4; i++) expect_cyc("single run", 1, 1, i, 0);
      expect_cyc("single done", 0, 0, 0, 1);
      req = '0;
      expect_cyc("single idle", 0, 0, 0, 0);

      // All requesting with zero lengths: strict rotation 0,1,2,3,0.
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         expect_cyc("rotate run",  1 << (i % 4), 1, 0, 0);
         expect_cyc("rotate done", 0, 0, 0, 1 << (i % 4));
         expect_cyc("rotate idle", 0, 0, 0, 0);
      end
      req = '0;

      // Requesters 0 and 2: 0 for three cycles, then 2 for two, 1 never.
      do_reset();
      req = 4'b0101; set_len(0, 2); set_len(2, 1);
      for (int i = 0; i < 3; i++) expect_cyc("pair r0", 1, 1, i, 0);
      expect_cyc("pair done0", 0, 0, 0, 1);
      req = 4'b0100;
      expect_cyc("pair idle", 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) expect_cyc("pair r2", 4, 1, i, 0);
      expect_cyc("pair done2", 0, 0, 0, 4);
      req = '0;
      expect_cyc("pair idle2", 0, 0, 0, 0);

      // Reset cuts a len 10 interval at q=5; then requester 3 wins alone.
      do_reset();
      req = 4'b0001; set_len(0, 10);
      for (int i = 0; i < 6; i++) expect_cyc("cut run", 1, 1, i, 0);
      rst = 1'b1;
      expect_cyc("cut reset", 0, 0, 0, 0);
      rst = 1'b0; req = 4'b1000; set_len(3, 2);
      for (int i = 0; i < 3; i++) expect_cyc("after cut r3", 8, 1, i, 0);
      expect_cyc("after cut done", 0, 0, 0, 8);
      req = '0;
      expect_cyc("after cut idle", 0, 0, 0, 0);

      // Abort at q=2 of len 7 (runs to completion when abort is compiled out).
      do_reset();
      req = 4'b0001; set_len(0, 7);
      expect_cyc("abort run", 1, 1, 0, 0);
      req = '0;
      for (int i = 1; i < 3; i++) expect_cyc("abort run", 1, 1, i, 0);
`ifdef DL_TIMER_ARB_ABORT_EN
      abort = 1'b1;
      expect_cyc("abort idle", 0, 0, 0, 0);
      abort = 1'b0;
      expect_cyc("abort stay idle", 0, 0, 0, 0);
`else
      for (int i = 3; i < 8; i++) expect_cyc("noabort run", 1, 1, i, 0);
      expect_cyc("noabort done", 0, 0, 0, 1);
`endif

      // Length change mid-RUN is ignored.
      do_reset();
      req = 4'b0010; set_len(1, 5);
      expect_cyc("len hold run", 2, 1, 0, 0);
      set_len(1, 1); req = '0;
      for (int i = 1; i < 6; i++) expect_cyc("len hold run", 2, 1, i, 0);
      expect_cyc("len hold done", 0, 0, 0, 2);
      expect_cyc("len hold idle", 0, 0, 0, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom);
         for (int i = 0; i < NR; i++) set_len(i, $urandom_range(0, 6));
         rst = ($urandom_range(0, 149) == 0);
`ifdef DL_TIMER_ARB_ABORT_EN
         abort = ($urandom_range(0, 39) == 0);
`endif
      end
      @(negedge clk);
      rst = 1'b0; req = '0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
